// File: rtl/vu_mask_ctrl.sv
// Per-lane condition/mask controller: runs compares through the shared adder and keeps a nested IF/ELSE/ENDIF mask stack.
// Optional compare-return watchdog enabled by defining VU_MASK_CTRL_TIMEOUT_EN (adds O_Timeout).
module vu_mask_ctrl #(
  parameter int NUM_LANES   = 4,
  parameter int WIDTH_DATA  = 32,
  parameter int STACK_DEPTH = 4
`ifdef VU_MASK_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT     = 64
`endif
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 I_Cmd_Valid,
  input  logic [1:0]                           I_Cmd_Op,
  input  logic [1:0]                           I_Cmd_Cond,
  output logic                                 O_Cmd_Ready,
  output logic                                 O_Cmp_Req,
  input  logic                                 I_Cmp_Ack,
  input  logic                                 I_Diff_Valid,
  input  logic [NUM_LANES*WIDTH_DATA-1:0]      I_Diff_Data,
  output logic [NUM_LANES-1:0]                 O_Mask,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     O_Depth,
  output logic                                 O_Overflow,
  output logic                                 O_Underflow
`ifdef VU_MASK_CTRL_TIMEOUT_EN
  ,
  output logic                                 O_Timeout
`endif
);

  localparam int DW = $clog2(STACK_DEPTH+1);
  localparam logic [DW-1:0] MAX_DEPTH = DW'(STACK_DEPTH);
  localparam logic [1:0] OP_IF    = 2'b01;
  localparam logic [1:0] OP_ELSE  = 2'b10;
  localparam logic [1:0] OP_ENDIF = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, UPDATE} state_t;
  state_t state, state_nxt;

  logic [DW-1:0]        depth, depth_inc;
  logic [NUM_LANES-1:0] mask_stk [0:STACK_DEPTH];
  logic [NUM_LANES-1:0] cond_stk [0:STACK_DEPTH];
  logic [NUM_LANES-1:0] mask_q, parent_mask, lane_cond, cond_cap;
  logic [1:0]           cond_sel;
  logic                 cmd_acc, diff_take, timeout_hit;
  logic                 overflow_q, underflow_q;

  // Sign bit is ignored for equality, so a negative zero difference counts as equal
  function automatic logic lane_flag(input logic [WIDTH_DATA-1:0] d, input logic [1:0] sel);
    logic eq;
    eq = (d[WIDTH_DATA-2:0] == '0);
    case (sel)
      2'd0:    lane_flag = eq;
      2'd1:    lane_flag = ~eq;
      2'd2:    lane_flag = d[WIDTH_DATA-1] & ~eq;
      default: lane_flag = ~d[WIDTH_DATA-1];
    endcase
  endfunction

  assign cmd_acc     = I_Cmd_Valid & (state == IDLE);
  assign diff_take   = I_Diff_Valid & (((state == REQ) & I_Cmp_Ack) | (state == WAIT));
  assign depth_inc   = depth + 1'b1;
  assign parent_mask = (depth <= DW'(1)) ? '1 : mask_stk[depth - 1'b1];

  assign O_Cmd_Ready = (state == IDLE);
  assign O_Mask      = mask_q;
  assign O_Depth     = depth;
  assign O_Overflow  = overflow_q;
  assign O_Underflow = underflow_q;

  always_comb begin
    lane_cond = '0;
    for (int i = 0; i < NUM_LANES; i++)
      lane_cond[i] = lane_flag(I_Diff_Data[i*WIDTH_DATA +: WIDTH_DATA], cond_sel);
  end

`ifdef VU_MASK_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] wait_cnt;
  logic          timeout_q;

  assign timeout_hit = (state == WAIT) & ~I_Diff_Valid & (wait_cnt == TW'(TIMEOUT-1));
  assign O_Timeout   = timeout_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state == WAIT) && !I_Diff_Valid) wait_cnt <= wait_cnt + 1'b1;
      else                                   wait_cnt <= '0;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    O_Cmp_Req = 1'b0;
    case (state)
      IDLE:   if (cmd_acc && (I_Cmd_Op == OP_IF) && (depth < MAX_DEPTH)) state_nxt = REQ;
      REQ: begin
        O_Cmp_Req = 1'b1;
        if (I_Cmp_Ack) state_nxt = I_Diff_Valid ? UPDATE : WAIT;
      end
      WAIT:   if (I_Diff_Valid || timeout_hit) state_nxt = UPDATE;
      UPDATE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mask_q always mirrors mask[depth]; every stack write updates it in the same edge
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      depth       <= '0;
      mask_q      <= '1;
      cond_sel    <= '0;
      cond_cap    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int k = 0; k <= STACK_DEPTH; k++) begin
        mask_stk[k] <= '1;
        cond_stk[k] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (cmd_acc) begin
        case (I_Cmd_Op)
          OP_IF: begin
            if (depth == MAX_DEPTH) overflow_q <= 1'b1;
            else                    cond_sel   <= I_Cmd_Cond;
          end
          OP_ELSE: begin
            if (depth == '0) underflow_q <= 1'b1;
            else begin
              mask_stk[depth] <= parent_mask & ~cond_stk[depth];
              cond_stk[depth] <= ~cond_stk[depth];
              mask_q          <= parent_mask & ~cond_stk[depth];
            end
          end
          OP_ENDIF: begin
            if (depth == '0) underflow_q <= 1'b1;
            else begin
              depth  <= depth - 1'b1;
              mask_q <= parent_mask;
            end
          end
          default: ;
        endcase
      end
      if (diff_take)        cond_cap <= lane_cond;
      else if (timeout_hit) cond_cap <= '0;
      if (state == UPDATE) begin
        depth               <= depth_inc;
        mask_stk[depth_inc] <= mask_q & cond_cap;
        cond_stk[depth_inc] <= cond_cap;
        mask_q              <= mask_q & cond_cap;
      end
    end
  end

endmodule

// File: tb/tb_vu_mask_ctrl.sv
// Randomised bench for vu_mask_ctrl against a queue-based mask-stack model.
// Define VU_MASK_CTRL_TIMEOUT_EN to also exercise the compare-return watchdog (TIMEOUT=8).
module tb_vu_mask_ctrl;

  localparam int NL = 4;
  localparam int WD = 32;
  localparam int SD = 4;
  localparam logic [1:0] OP_NOP = 2'b00, OP_IF = 2'b01, OP_ELSE = 2'b10, OP_ENDIF = 2'b11;
  localparam logic [1:0] C_EQ = 2'd0, C_NE = 2'd1, C_GT = 2'd2, C_LE = 2'd3;
`ifdef VU_MASK_CTRL_TIMEOUT_EN
  localparam int TMO = 8;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic I_Cmd_Valid = 1'b0;
  logic [1:0] I_Cmd_Op = 2'b00;
  logic [1:0] I_Cmd_Cond = 2'b00;
  logic O_Cmd_Ready, O_Cmp_Req;
  logic I_Cmp_Ack = 1'b0;
  logic I_Diff_Valid = 1'b0;
  logic [NL*WD-1:0] I_Diff_Data = '0;
  logic [NL-1:0] O_Mask;
  logic [2:0] O_Depth;
  logic O_Overflow, O_Underflow;
`ifdef VU_MASK_CTRL_TIMEOUT_EN
  logic O_Timeout;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // Model: queue of pushed masks/conds, depth is the queue size
  logic [NL-1:0] m_mask[$];
  logic [NL-1:0] m_cond[$];
  bit m_ovf = 0, m_unf = 0, m_to = 0;
  bit check_en = 0;

  vu_mask_ctrl #(
    .NUM_LANES(NL), .WIDTH_DATA(WD), .STACK_DEPTH(SD)
`ifdef VU_MASK_CTRL_TIMEOUT_EN
    , .TIMEOUT(TMO)
`endif
  ) dut (
    .clock(clock), .reset(reset),
    .I_Cmd_Valid(I_Cmd_Valid), .I_Cmd_Op(I_Cmd_Op), .I_Cmd_Cond(I_Cmd_Cond),
    .O_Cmd_Ready(O_Cmd_Ready), .O_Cmp_Req(O_Cmp_Req), .I_Cmp_Ack(I_Cmp_Ack),
    .I_Diff_Valid(I_Diff_Valid), .I_Diff_Data(I_Diff_Data),
    .O_Mask(O_Mask), .O_Depth(O_Depth),
    .O_Overflow(O_Overflow), .O_Underflow(O_Underflow)
`ifdef VU_MASK_CTRL_TIMEOUT_EN
    , .O_Timeout(O_Timeout)
`endif
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NL-1:0] model_top();
    return (m_mask.size() == 0) ? '1 : m_mask[m_mask.size()-1];
  endfunction

  function automatic logic [NL-1:0] model_parent();
    return (m_mask.size() <= 1) ? '1 : m_mask[m_mask.size()-2];
  endfunction

  // Flags from the numeric value: negative means >= 2^31, zero means magnitude divisible by 2^31
  function automatic logic [NL-1:0] lane_flags(input logic [NL*WD-1:0] data, input logic [1:0] sel);
    logic [NL-1:0] r;
    logic [WD-1:0] v;
    bit neg, zmag;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      v    = data[i*WD +: WD];
      neg  = (v >= 32'h8000_0000);
      zmag = ((v % 32'h8000_0000) == 0);
      case (sel)
        C_EQ:    r[i] = zmag;
        C_NE:    r[i] = !zmag;
        C_GT:    r[i] = neg && !zmag;
        default: r[i] = !neg;
      endcase
    end
    return r;
  endfunction

  function automatic logic [NL*WD-1:0] rand_diff();
    logic [NL*WD-1:0] r;
    logic [WD-1:0] v;
    for (int i = 0; i < NL; i++) begin
      case ($urandom_range(0, 3))
        0:       v = 32'h0;
        1:       v = 32'h8000_0000;
        2:       v = ($urandom & 32'h7FFF_FFFF) | 32'h1;
        default: v = $urandom | 32'h8000_0001;
      endcase
      r[i*WD +: WD] = v;
    end
    return r;
  endfunction

  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("mask", {28'h0, O_Mask}, {28'h0, model_top()});
      checkOutput("depth", {29'h0, O_Depth}, m_mask.size());
      checkOutput("overflow", {31'h0, O_Overflow}, {31'h0, m_ovf});
      checkOutput("underflow", {31'h0, O_Underflow}, {31'h0, m_unf});
`ifdef VU_MASK_CTRL_TIMEOUT_EN
      checkOutput("timeout", {31'h0, O_Timeout}, {31'h0, m_to});
`endif
    end
  end

  // Issues one command starting just after a rising edge with the DUT idle; diff_dly < 0 means no diff returns
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] cond, input int ack_dly,
                               input int diff_dly, input logic [NL*WD-1:0] data);
    logic [NL-1:0] c;
    I_Cmd_Valid = 1'b1;
    I_Cmd_Op    = op;
    I_Cmd_Cond  = cond;
    if (op == OP_NOP) begin
      I_Diff_Valid = 1'b1;
      I_Diff_Data  = rand_diff();
    end
    @(negedge clock);
    checkOutput("ready_idle", {31'h0, O_Cmd_Ready}, 32'h1);
    checkOutput("req_idle", {31'h0, O_Cmp_Req}, 32'h0);
    @(posedge clock); #1;
    I_Cmd_Valid  = 1'b0;
    I_Cmd_Op     = 2'($urandom);
    I_Cmd_Cond   = 2'($urandom);
    I_Diff_Valid = 1'b0;
    case (op)
      OP_ELSE: begin
        if (m_mask.size() == 0) m_unf = 1;
        else begin
          c = m_cond[m_cond.size()-1];
          m_mask[m_mask.size()-1] = model_parent() & ~c;
          m_cond[m_cond.size()-1] = ~c;
        end
      end
      OP_ENDIF: begin
        if (m_mask.size() == 0) m_unf = 1;
        else begin
          void'(m_mask.pop_back());
          void'(m_cond.pop_back());
        end
      end
      OP_IF: begin
        if (m_mask.size() == SD) begin
          m_ovf = 1;
          @(negedge clock);
          checkOutput("ovf_no_req", {31'h0, O_Cmp_Req}, 32'h0);
          checkOutput("ovf_ready", {31'h0, O_Cmd_Ready}, 32'h1);
          @(posedge clock); #1;
        end else begin
          for (int k = 0; k < ack_dly; k++) begin
            @(negedge clock);
            checkOutput("req_hold", {31'h0, O_Cmp_Req}, 32'h1);
            checkOutput("ready_busy", {31'h0, O_Cmd_Ready}, 32'h0);
            @(posedge clock); #1;
          end
          I_Cmp_Ack = 1'b1;
          if (diff_dly == 0) begin
            I_Diff_Valid = 1'b1;
            I_Diff_Data  = data;
          end
          @(negedge clock);
          checkOutput("req_ack", {31'h0, O_Cmp_Req}, 32'h1);
          @(posedge clock); #1;
          I_Cmp_Ack    = 1'b0;
          I_Diff_Valid = 1'b0;
          if (diff_dly > 0) begin
            for (int k = 0; k < diff_dly - 1; k++) begin
              @(negedge clock);
              checkOutput("wait_no_req", {31'h0, O_Cmp_Req}, 32'h0);
              checkOutput("wait_busy", {31'h0, O_Cmd_Ready}, 32'h0);
              @(posedge clock); #1;
            end
            I_Diff_Valid = 1'b1;
            I_Diff_Data  = data;
            @(negedge clock);
            checkOutput("wait_no_req", {31'h0, O_Cmp_Req}, 32'h0);
            @(posedge clock); #1;
            I_Diff_Valid = 1'b0;
          end else if (diff_dly < 0) begin
`ifdef VU_MASK_CTRL_TIMEOUT_EN
            for (int k = 0; k < TMO; k++) begin
              @(negedge clock);
              checkOutput("to_wait_busy", {31'h0, O_Cmd_Ready}, 32'h0);
              @(posedge clock); #1;
            end
`endif
          end
          @(negedge clock);
          checkOutput("update_busy", {31'h0, O_Cmd_Ready}, 32'h0);
          @(posedge clock); #1;
          c = (diff_dly < 0) ? '0 : lane_flags(data, cond);
          if (diff_dly < 0) m_to = 1;
          m_mask.push_back(model_top() & c);
          m_cond.push_back(c);
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_mask.delete();
    m_cond.delete();
    m_ovf = 0;
    m_unf = 0;
    m_to  = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] op;
    int r;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    check_en = 1;
    @(negedge clock);
    checkOutput("rst_ready", {31'h0, O_Cmd_Ready}, 32'h1);
    checkOutput("rst_req", {31'h0, O_Cmp_Req}, 32'h0);
    checkOutput("rst_mask", {28'h0, O_Mask}, 32'hF);
    checkOutput("rst_depth", {29'h0, O_Depth}, 32'h0);
    @(posedge clock); #1;

    applyStimulus(OP_IF, C_GT, 2, 1, {32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'h8000_0001});
    checkOutput("tp1_mask", {28'h0, O_Mask}, 32'h1);
    checkOutput("tp1_depth", {29'h0, O_Depth}, 32'h1);
    applyStimulus(OP_ELSE, C_EQ, 0, 0, '0);
    checkOutput("tp2_else", {28'h0, O_Mask}, 32'hE);
    applyStimulus(OP_ELSE, C_EQ, 0, 0, '0);
    checkOutput("tp2_else2", {28'h0, O_Mask}, 32'h1);
    applyStimulus(OP_ENDIF, C_EQ, 0, 0, '0);
    checkOutput("tp2_endif", {28'h0, O_Mask}, 32'hF);
    checkOutput("tp2_depth", {29'h0, O_Depth}, 32'h0);

    applyStimulus(OP_IF, C_EQ, 0, 0, {32'h0, 32'h5, 32'h0, 32'h0});
    checkOutput("tp3_eq", {28'h0, O_Mask}, 32'hB);
    applyStimulus(OP_IF, C_LE, 1, 2, {32'h8000_0001, 32'h0, 32'h0, 32'h8000_0002});
    checkOutput("tp3_le", {28'h0, O_Mask}, 32'h2);
    applyStimulus(OP_ENDIF, C_EQ, 0, 0, '0);
    checkOutput("tp3_endif", {28'h0, O_Mask}, 32'hB);
    applyStimulus(OP_ENDIF, C_EQ, 0, 0, '0);

    for (int k = 0; k < SD; k++) applyStimulus(OP_IF, C_LE, 0, 1, '0);
    applyStimulus(OP_IF, C_EQ, 0, 1, '0);
    checkOutput("tp4_ovf", {31'h0, O_Overflow}, 32'h1);
    checkOutput("tp4_depth", {29'h0, O_Depth}, 32'h4);
    checkOutput("tp4_mask", {28'h0, O_Mask}, 32'hF);
    for (int k = 0; k < SD; k++) applyStimulus(OP_ENDIF, C_EQ, 0, 0, '0);

    applyStimulus(OP_ENDIF, C_EQ, 0, 0, '0);
    checkOutput("tp5_unf", {31'h0, O_Underflow}, 32'h1);
    checkOutput("tp5_mask", {28'h0, O_Mask}, 32'hF);

    // Reset while the compare is outstanding, then a stale difference arrives
    I_Cmd_Valid = 1'b1; I_Cmd_Op = OP_IF; I_Cmd_Cond = C_EQ;
    @(posedge clock); #1;
    I_Cmd_Valid = 1'b0; I_Cmp_Ack = 1'b1;
    @(posedge clock); #1;
    I_Cmp_Ack = 1'b0;
    @(negedge clock);
    checkOutput("tp5_wait_req", {31'h0, O_Cmp_Req}, 32'h0);
    @(posedge clock); #1;
    check_en = 0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    check_en = 1;
    I_Diff_Valid = 1'b1; I_Diff_Data = '0;
    @(posedge clock); #1;
    I_Diff_Valid = 1'b0;
    repeat (2) begin
      @(negedge clock);
      checkOutput("tp5_rst_ready", {31'h0, O_Cmd_Ready}, 32'h1);
      checkOutput("tp5_rst_req", {31'h0, O_Cmp_Req}, 32'h0);
      checkOutput("tp5_rst_depth", {29'h0, O_Depth}, 32'h0);
      checkOutput("tp5_rst_flags", {30'h0, O_Overflow, O_Underflow}, 32'h0);
    end
    @(posedge clock); #1;

`ifdef VU_MASK_CTRL_TIMEOUT_EN
    applyStimulus(OP_IF, C_LE, 0, -1, '0);
    checkOutput("tp6_timeout", {31'h0, O_Timeout}, 32'h1);
    checkOutput("tp6_mask", {28'h0, O_Mask}, 32'h0);
    checkOutput("tp6_depth", {29'h0, O_Depth}, 32'h1);
`endif

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      op = (r < 40) ? OP_IF : (r < 60) ? OP_ELSE : (r < 85) ? OP_ENDIF : OP_NOP;
      applyStimulus(op, 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), rand_diff());
    end

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
